// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch AXI read master.
package ifetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned LOCK_W  = 2;
    localparam int unsigned CACHE_W = 4;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [RESP_W-1:0]  RESP_OKAY  = 2'b00;

    // Top address bits selecting the unmapped kernel segments.
    localparam logic [1:0] KSEG01_HI = 2'b10;
    localparam logic [2:0] KSEG0     = 3'b100;
    localparam logic [2:0] KSEG1     = 3'b101;

    localparam logic [CACHE_W-1:0] CACHE_UNCACHED = 4'b0000;
    localparam logic [CACHE_W-1:0] CACHE_WBWA     = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0]    addr;
        logic [CACHE_W-1:0] cache;
    } ar_xlate_t;

endpackage

// File: rtl/ifetch_addr_xlate.sv
// Virtual-to-physical mapping for fetch addresses: strips the kseg0/kseg1
// window and marks kseg1 as uncached.
module ifetch_addr_xlate
    import ifetch_pkg::*;
(
    input  logic [XLEN-1:0] vaddr,
    output ar_xlate_t       xlate
);

    always_comb begin
        xlate.addr  = vaddr;
        xlate.cache = CACHE_WBWA;
        if (vaddr[31:30] == KSEG01_HI) begin
            xlate.addr = {3'b000, vaddr[28:0]};
        end
        if (vaddr[31:29] == KSEG1) begin
            xlate.cache = CACHE_UNCACHED;
        end
    end

endmodule

// File: rtl/ifetch_axi_rd.sv
// Instruction-fetch read master: one outstanding single-beat AXI4 read per
// fetch request, with misalignment faults and flush-driven response discard.
module ifetch_axi_rd
    import ifetch_pkg::*;
#(
    parameter int unsigned ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [XLEN-1:0]     req_pc,
    output logic                req_ready,
    input  logic                flush,
    output logic                inst_valid,
    output logic [XLEN-1:0]     inst,
    output logic [XLEN-1:0]     inst_pc,
    output logic                inst_err,
    input  logic                inst_ready,
    output logic [ID_W-1:0]     arid,
    output logic [XLEN-1:0]     araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic [SIZE_W-1:0]   arsize,
    output logic [BURST_W-1:0]  arburst,
    output logic [LOCK_W-1:0]   arlock,
    output logic [CACHE_W-1:0]  arcache,
    output logic [PROT_W-1:0]   arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [XLEN-1:0]     rdata,
    input  logic [RESP_W-1:0]   rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    state_e    state;
    logic      discard;
    ar_xlate_t xl;
    logic      unused_r;

    ifetch_addr_xlate u_xlate (
        .vaddr (req_pc),
        .xlate (xl)
    );

    // Single beat, single ID: the R-channel tag and last flag carry no information.
    assign unused_r = ^{rid, rlast};

    assign arid    = '0;
    assign arlen   = '0;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arprot  = '0;

    // A flush in IDLE blocks the request so no stale-path fetch is started.
    assign req_ready = (state == ST_IDLE) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            discard    <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst_valid <= 1'b0;
            inst_err   <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            araddr     <= '0;
            arcache    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    discard <= 1'b0;
                    if (req_valid && !flush) begin
                        inst_pc <= req_pc;
                        if (req_pc[1:0] != 2'b00) begin
                            inst       <= '0;
                            inst_err   <= 1'b1;
                            inst_valid <= 1'b1;
                            state      <= ST_OUT;
                        end else begin
                            araddr  <= xl.addr;
                            arcache <= xl.cache;
                            arvalid <= 1'b1;
                            state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    // The address must still be handed off even when killed.
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (discard || flush) begin
                            discard <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            inst       <= (rresp == RESP_OKAY) ? rdata : '0;
                            inst_err   <= (rresp != RESP_OKAY);
                            inst_valid <= 1'b1;
                            state      <= ST_OUT;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_axi_rd.sv
// Self-checking bench for ifetch_axi_rd: directed scenarios plus randomized
// back-to-back fetches against an address-map and response model.
module tb_ifetch_axi_rd;

    localparam int unsigned ID_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic [31:0]     req_pc;
    logic            req_ready;
    logic            flush;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [31:0]     inst_pc;
    logic            inst_err;
    logic            inst_ready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_axi_rd #(.ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_err   (inst_err),
        .inst_ready (inst_ready),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arlock     (arlock),
        .arcache    (arcache),
        .arprot     (arprot),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    // Address map: kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto the low
    // 512 MB; only kseg1 (0xA000_0000..0xBFFF_FFFF) is uncached.
    function automatic logic [35:0] ref_ar(input logic [31:0] va);
        logic [31:0] pa;
        logic [3:0]  c;
        pa = va;
        c  = 4'hF;
        if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) pa = va % 32'h2000_0000;
        if (va >= 32'hA000_0000 && va <= 32'hBFFF_FFFF) c = 4'h0;
        return {c, pa};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = 1'b0;
        req_pc     = 32'h0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rid        = '0;
        rlast      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, inst_valid, inst_err, req_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {arvalid, rready, inst_valid, inst_err, req_ready}, 5'b00001);
        end
        checks++;
        if ({inst, inst_pc, araddr} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {inst, inst_pc, araddr});
        end
        checks++;
        if ({arid, arlen, arsize, arburst, arlock, arprot} !== {4'h0, 8'h00, 3'b010, 2'b01, 2'b00, 3'b000}) begin
            errors++;
            $display("FAIL ar_fixed: got %h expected %h", {arid, arlen, arsize, arburst, arlock, arprot},
                     {4'h0, 8'h00, 3'b010, 2'b01, 2'b00, 3'b000});
        end
    endtask

    task automatic test_aligned_kseg1();
        req_valid = 1'b1;
        req_pc    = 32'hBFC0_0000;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL k1_req_ready: got %b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        req_pc    = 32'h1234_5678;
        arready   = 1'b1;
        #1;
        checks++;
        if ({arvalid, araddr, arcache} !== {1'b1, 32'h1FC0_0000, 4'h0}) begin
            errors++;
            $display("FAIL k1_ar: got %h expected %h", {arvalid, araddr, arcache}, {1'b1, 32'h1FC0_0000, 4'h0});
        end
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h3C1D_0001;
        rresp   = 2'b00;
        #1;
        checks++;
        if ({arvalid, rready, inst_valid} !== 3'b010) begin
            errors++;
            $display("FAIL k1_r_phase: got %b expected 010", {arvalid, rready, inst_valid});
        end
        tick();
        rvalid     = 1'b0;
        inst_ready = 1'b1;
        #1;
        checks++;
        if ({inst_valid, inst_err, rready, inst, inst_pc} !== {1'b1, 1'b0, 1'b0, 32'h3C1D_0001, 32'hBFC0_0000}) begin
            errors++;
            $display("FAIL k1_inst: got %h expected %h", {inst_valid, inst_err, rready, inst, inst_pc},
                     {1'b1, 1'b0, 1'b0, 32'h3C1D_0001, 32'hBFC0_0000});
        end
        tick();
        inst_ready = 1'b0;
        #1;
        checks++;
        if ({inst_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL k1_back_idle: got %b expected 01", {inst_valid, req_ready});
        end
    endtask

    task automatic test_misaligned();
        req_valid = 1'b1;
        req_pc    = 32'hBFC0_0002;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_ready = (i == 2);
            #1;
            checks++;
            if ({arvalid, inst_valid, inst_err, inst, inst_pc} !== {1'b0, 1'b1, 1'b1, 32'h0, 32'hBFC0_0002}) begin
                errors++;
                $display("FAIL misalign_out: got %h expected %h", {arvalid, inst_valid, inst_err, inst, inst_pc},
                         {1'b0, 1'b1, 1'b1, 32'h0, 32'hBFC0_0002});
            end
            tick();
        end
        inst_ready = 1'b0;
        #1;
        checks++;
        if ({arvalid, inst_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL misalign_idle: got %b expected 001", {arvalid, inst_valid, req_ready});
        end
    endtask

    task automatic test_flush_in_ar();
        req_valid = 1'b1;
        req_pc    = 32'h0040_0100;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            arready = (i == 5);
            flush   = (i == 2);
            #1;
            checks++;
            if ({arvalid, araddr, arcache} !== {1'b1, 32'h0040_0100, 4'hF}) begin
                errors++;
                $display("FAIL flush_ar_hold cyc%0d: got %h expected %h", i, {arvalid, araddr, arcache},
                         {1'b1, 32'h0040_0100, 4'hF});
            end
            tick();
        end
        arready = 1'b0;
        flush   = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_r_ready: got %b expected 01", {arvalid, rready});
        end
        tick();
        rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({inst_valid, rready, req_ready} !== 3'b001) begin
                errors++;
                $display("FAIL flush_dropped cyc%0d: got %b expected 001", i, {inst_valid, rready, req_ready});
            end
            tick();
        end
    endtask

    task automatic test_rresp_err();
        req_valid = 1'b1;
        req_pc    = 32'h8000_0010;
        tick();
        req_valid = 1'b0;
        arready   = 1'b1;
        #1;
        checks++;
        if ({arvalid, araddr, arcache} !== {1'b1, 32'h0000_0010, 4'hF}) begin
            errors++;
            $display("FAIL err_ar: got %h expected %h", {arvalid, araddr, arcache}, {1'b1, 32'h0000_0010, 4'hF});
        end
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hDEAD_BEEF;
        rresp   = 2'b10;
        tick();
        rvalid     = 1'b0;
        rresp      = 2'b00;
        inst_ready = 1'b1;
        #1;
        checks++;
        if ({inst_valid, inst_err, inst, inst_pc} !== {1'b1, 1'b1, 32'h0, 32'h8000_0010}) begin
            errors++;
            $display("FAIL err_inst: got %h expected %h", {inst_valid, inst_err, inst, inst_pc},
                     {1'b1, 1'b1, 32'h0, 32'h8000_0010});
        end
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_backpressure_flush_out();
        logic [31:0] pc;
        logic [31:0] rd;
        pc = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFC);
        rd = $urandom;
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
        arready   = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = rd;
        tick();
        rvalid = 1'b0;
        rdata  = ~rd;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({inst_valid, inst_err, inst, inst_pc} !== {1'b1, 1'b0, rd, pc}) begin
                errors++;
                $display("FAIL bp_stable cyc%0d: got %h expected %h", i, {inst_valid, inst_err, inst, inst_pc},
                         {1'b1, 1'b0, rd, pc});
            end
            tick();
        end
        flush      = 1'b1;
        inst_ready = 1'b1;
        tick();
        flush      = 1'b0;
        inst_ready = 1'b0;
        #1;
        checks++;
        if ({inst_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_flush_out: got %b expected 01", {inst_valid, req_ready});
        end
        req_valid = 1'b1;
        req_pc    = 32'h0000_1000;
        flush     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_block: got %b expected 0", req_ready);
        end
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        checks++;
        if ({arvalid, inst_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL idle_flush_noaccept: got %b expected 001", {arvalid, inst_valid, req_ready});
        end
    endtask

    task automatic test_reset_in_r();
        req_valid = 1'b1;
        req_pc    = 32'h0001_0040;
        tick();
        req_valid = 1'b0;
        arready   = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_r_setup: got %b expected 1", rready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, inst_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_in_r: got %b expected 0001", {arvalid, rready, inst_valid, req_ready});
        end
        rvalid = 1'b1;
        rdata  = 32'h1111_2222;
        tick();
        rvalid = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, inst_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_stray_r: got %b expected 0001", {arvalid, rready, inst_valid, req_ready});
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] pc;
        logic [35:0] exp_ar;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [31:0] exp_inst;
        logic        exp_err;
        int          wait_n;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       pc = $urandom & 32'h7FFF_FFFF;
                1:       pc = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
                2:       pc = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
                default: pc = 32'hC000_0000 | ($urandom & 32'h3FFF_FFFF);
            endcase
            pc = pc & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) pc = pc | 32'($urandom_range(1, 3));
            exp_ar = ref_ar(pc);
            repeat ($urandom_range(0, 2)) tick();
            req_valid = 1'b1;
            req_pc    = pc;
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_req_ready #%0d: got %b expected 1", n, req_ready);
            end
            tick();
            req_valid = 1'b0;
            req_pc    = $urandom;
            if (pc[1:0] != 2'b00) begin
                exp_inst = 32'h0;
                exp_err  = 1'b1;
            end else begin
                wait_n = $urandom_range(0, 3);
                for (int i = 0; i <= wait_n; i++) begin
                    arready = (i == wait_n);
                    #1;
                    checks++;
                    if ({arvalid, rready, araddr, arcache} !== {1'b1, 1'b0, exp_ar[31:0], exp_ar[35:32]}) begin
                        errors++;
                        $display("FAIL rnd_ar #%0d pc=%h: got %h expected %h", n, pc, {arvalid, rready, araddr, arcache},
                                 {1'b1, 1'b0, exp_ar[31:0], exp_ar[35:32]});
                    end
                    tick();
                end
                arready = 1'b0;
                rd      = $urandom;
                rs      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                wait_n  = $urandom_range(0, 3);
                for (int i = 0; i <= wait_n; i++) begin
                    rvalid = (i == wait_n);
                    rdata  = rvalid ? rd : $urandom;
                    rresp  = rvalid ? rs : 2'($urandom);
                    #1;
                    checks++;
                    if ({arvalid, rready, inst_valid} !== 3'b010) begin
                        errors++;
                        $display("FAIL rnd_r #%0d: got %b expected 010", n, {arvalid, rready, inst_valid});
                    end
                    tick();
                end
                rvalid   = 1'b0;
                rresp    = 2'b00;
                exp_inst = (rs == 2'b00) ? rd : 32'h0;
                exp_err  = (rs != 2'b00);
            end
            wait_n = $urandom_range(0, 2);
            for (int i = 0; i <= wait_n; i++) begin
                inst_ready = (i == wait_n);
                #1;
                checks++;
                if ({arvalid, rready, inst_valid, inst_err, inst, inst_pc} !== {1'b0, 1'b0, 1'b1, exp_err, exp_inst, pc}) begin
                    errors++;
                    $display("FAIL rnd_out #%0d: got %h expected %h", n, {arvalid, rready, inst_valid, inst_err, inst, inst_pc},
                             {1'b0, 1'b0, 1'b1, exp_err, exp_inst, pc});
                end
                tick();
            end
            inst_ready = 1'b0;
            #1;
            checks++;
            if ({inst_valid, req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL rnd_idle #%0d: got %b expected 01", n, {inst_valid, req_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_kseg1();
        test_misaligned();
        test_flush_in_ar();
        test_rresp_err();
        test_backpressure_flush_out();
        test_reset_in_r();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
